// File: rtl/carriles_vehiculos_param.sv
// rtl/carriles_vehiculos_param.sv - parametrised Frogger vehicle-lane generator (optional LFSR traffic: CV_LFSR_EN)
module carriles_vehiculos_param #(
    parameter int                         DATAWIDTH_BUS = 8,
    parameter int                         NUM_LANES     = 6,
    parameter int                         DATAWIDTH_NVL = 2,
    parameter int                         PRESC_W       = 24,
    parameter logic [PRESC_W-1:0]         BASE_PERIOD   = 24'd5000000,
    parameter logic [DATAWIDTH_BUS-1:0]   SEED          = 8'b0000_0011
) (
    input  logic                                 CV_CLOCK,
    input  logic                                 CV_RESET,
    input  logic [DATAWIDTH_NVL-1:0]             CV_NV_IN,
    input  logic                                 CV_CN_IN,
    input  logic                                 CV_PAUSE_IN,
    output logic [NUM_LANES*DATAWIDTH_BUS-1:0]   CV_LANES_OUT,
    output logic                                 CV_TICK_OUT,
    output logic [1:0]                           CV_STATE_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [DATAWIDTH_NVL-1:0]   r_level;
    logic [PRESC_W-1:0]         r_presc;
    logic [PRESC_W-1:0]         w_period_raw;
    logic [PRESC_W-1:0]         w_period;
    logic [PRESC_W-1:0]         w_period_last;
    logic                       r_tick;
    logic                       w_cn_take;
    logic                       w_run_active;
    logic                       w_expire;

    // Shift period for the latched level; a level that shifts the base to zero runs at one shift per cycle
    always_comb begin
        w_period_raw  = BASE_PERIOD >> r_level;
        w_period      = (w_period_raw == '0) ? PRESC_W'(1) : w_period_raw;
        w_period_last = w_period - PRESC_W'(1);
    end

    // Control decode: reload request, counting permission and expiry
    always_comb begin
        w_cn_take    = 1'b0;
        w_run_active = 1'b0;
        w_expire     = 1'b0;
        if (CV_CN_IN && (r_state == ST_IDLE || r_state == ST_RUN)) begin
            w_cn_take = 1'b1;
        end
        if (r_state == ST_RUN && !CV_CN_IN && !CV_PAUSE_IN) begin
            w_run_active = 1'b1;
        end
        w_expire = w_run_active && (r_presc == w_period_last);
    end

    // FSM state register
    always_ff @(posedge CV_CLOCK) begin
        if (CV_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: CN in IDLE or RUN forces a reload, LOAD always lasts one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (CV_CN_IN) w_state_next = ST_LOAD;
            ST_LOAD: w_state_next = ST_RUN;
            ST_RUN:  if (CV_CN_IN) w_state_next = ST_LOAD;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Level is captured only together with an accepted CN strobe
    always_ff @(posedge CV_CLOCK) begin
        if (CV_RESET) begin
            r_level <= '0;
        end else if (w_cn_take) begin
            r_level <= CV_NV_IN;
        end
    end

    // Prescaler: cleared by LOAD and on expiry, so it never passes the current period
    always_ff @(posedge CV_CLOCK) begin
        if (CV_RESET) begin
            r_presc <= '0;
        end else if (r_state == ST_LOAD || w_expire) begin
            r_presc <= '0;
        end else if (w_run_active) begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Tick rises with the same edge that makes the shifted lanes visible
    always_ff @(posedge CV_CLOCK) begin
        if (CV_RESET) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_expire;
        end
    end

`ifdef CV_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // Traffic LFSR advances once per shift and survives reloads
    always_ff @(posedge CV_CLOCK) begin
        if (CV_RESET) begin
            r_lfsr <= 16'hACE1;
        end else if (w_expire) begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam int                        ROT    = gi % DATAWIDTH_BUS;
            localparam logic [DATAWIDTH_BUS-1:0]  LOAD_V = (SEED << ROT) |
                                                           (SEED >> ((DATAWIDTH_BUS - ROT) % DATAWIDTH_BUS));
            logic [DATAWIDTH_BUS-1:0] r_q;
            logic [DATAWIDTH_BUS-1:0] w_shifted;
            logic                     w_in_bit;

            if (gi % 2 == 1) begin : g_odd
`ifdef CV_LFSR_EN
                assign w_in_bit = r_lfsr[gi % 16];
`else
                assign w_in_bit = r_q[0];
`endif
                assign w_shifted = {w_in_bit, r_q[DATAWIDTH_BUS-1:1]};
            end else begin : g_even
`ifdef CV_LFSR_EN
                assign w_in_bit = r_lfsr[gi % 16];
`else
                assign w_in_bit = r_q[DATAWIDTH_BUS-1];
`endif
                assign w_shifted = {r_q[DATAWIDTH_BUS-2:0], w_in_bit};
            end

            // Lane register: seeded on LOAD, shifted on expiry, cleared while idle
            always_ff @(posedge CV_CLOCK) begin
                if (CV_RESET) begin
                    r_q <= '0;
                end else if (r_state == ST_IDLE) begin
                    r_q <= '0;
                end else if (r_state == ST_LOAD) begin
                    r_q <= LOAD_V;
                end else if (w_expire) begin
                    r_q <= w_shifted;
                end
            end

            assign CV_LANES_OUT[gi*DATAWIDTH_BUS +: DATAWIDTH_BUS] = r_q;
        end
    endgenerate

    assign CV_TICK_OUT  = r_tick;
    assign CV_STATE_OUT = r_state;

endmodule

// File: tb/tb_carriles_vehiculos_param.sv
// tb/tb_carriles_vehiculos_param.sv - scoreboard bench for carriles_vehiculos_param
module tb_carriles_vehiculos_param;

    localparam int          W     = 8;
    localparam int          NL    = 6;
    localparam int          BASE  = 8;
    localparam int          SEEDV = 8'h03;

    logic        clk;
    logic        rst;
    logic        cn;
    logic        pause;
    logic [1:0]  nv;
    logic [47:0] lanes;
    logic        tick;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    carriles_vehiculos_param #(
        .DATAWIDTH_BUS (8),
        .NUM_LANES     (6),
        .DATAWIDTH_NVL (2),
        .PRESC_W       (24),
        .BASE_PERIOD   (24'd8),
        .SEED          (8'h03)
    ) dut (
        .CV_CLOCK     (clk),
        .CV_RESET     (rst),
        .CV_NV_IN     (nv),
        .CV_CN_IN     (cn),
        .CV_PAUSE_IN  (pause),
        .CV_LANES_OUT (lanes),
        .CV_TICK_OUT  (tick),
        .CV_STATE_OUT (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: 0 idle, 1 load, 2 run; m_count = run cycles since last load/shift
    int m_lane [NL];
    int m_state;
    int m_count;
    int m_level;
    int m_tick;
    int m_lfsr;

    logic [50:0] sb_q [$];

    function automatic int period(input int lvl);
        int p;
        p = BASE >> lvl;
        return (p == 0) ? 1 : p;
    endfunction

    function automatic int rotl(input int x, input int n);
        return ((x << n) | (x >> (8 - n))) & 255;
    endfunction

    task automatic model_shift();
        int inb;
        for (int i = 0; i < NL; i++) begin
`ifdef CV_LFSR_EN
            inb = (m_lfsr >> (i % 16)) & 1;
`else
            inb = (i % 2 == 1) ? (m_lane[i] & 1) : ((m_lane[i] >> 7) & 1);
`endif
            if (i % 2 == 1) m_lane[i] = (m_lane[i] >> 1) | (inb << 7);
            else            m_lane[i] = ((m_lane[i] << 1) & 255) | inb;
        end
`ifdef CV_LFSR_EN
        m_lfsr = (m_lfsr >> 1) |
                 ((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
`endif
    endtask

    task automatic model_step(input logic r, input logic c, input int v, input logic p);
        if (r) begin
            for (int i = 0; i < NL; i++) m_lane[i] = 0;
            m_state = 0; m_count = 0; m_level = 0; m_tick = 0; m_lfsr = 16'hACE1;
        end else begin
            m_tick = 0;
            if (m_state == 0) begin
                if (c) begin m_level = v; m_state = 1; end
            end else if (m_state == 1) begin
                for (int i = 0; i < NL; i++) m_lane[i] = rotl(SEEDV, i % W);
                m_count = 0;
                m_state = 2;
            end else begin
                if (c) begin
                    m_level = v; m_state = 1;
                end else if (!p) begin
                    m_count++;
                    if (m_count == period(m_level)) begin
                        m_count = 0;
                        model_shift();
                        m_tick = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [50:0] pack_exp();
        logic [47:0] l;
        for (int i = 0; i < NL; i++) l[i*8 +: 8] = 8'(m_lane[i]);
        return {2'(m_state), 1'(m_tick), l};
    endfunction

    task automatic step(input logic r, input logic c, input logic [1:0] v, input logic p);
        @(negedge clk);
        rst = r; cn = c; nv = v; pause = p;
        model_step(r, c, int'(v), p);
        sb_q.push_back(pack_exp());
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // monitor: one output set per clock, compared against the queued model response
    initial begin
        logic [50:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if ({state, tick, lanes} !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: state %h tick %b lanes %h, required state %h tick %b lanes %h",
                             $time, state, tick, lanes, e[50:49], e[48], e[47:0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; cn = 1'b0; nv = 2'd0; pause = 1'b0;

        // reset then idle
        repeat (3) step(1, 0, 0, 0);
        repeat (50) step(0, 0, 0, 0);
        settle();
        chk("idle_lanes", 64'(lanes), 64'h0);
        chk("idle_state", 64'(state), 64'h0);

        // start at level 0
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        settle();
        chk("load_lanes", 64'(lanes), 64'h6030180C0603);
        chk("load_state", 64'(state), 64'h1 << 1);
        repeat (7) step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        settle();
        chk("first_tick", 64'(tick), 64'h1);
`ifdef CV_LFSR_EN
        chk("first_lane0", 64'(lanes[7:0]), 64'h07);
        chk("first_lane5", 64'(lanes[47:40]), 64'hB0);
`else
        chk("first_lane0", 64'(lanes[7:0]), 64'h06);
        chk("first_lane5", 64'(lanes[47:40]), 64'h30);
`endif
        chk("first_lane1", 64'(lanes[15:8]), 64'h03);

        // pause mid-period with prescaler at 5
        repeat (5) step(0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        settle();
        chk("pause_no_early_tick", 64'(tick), 64'h0);
        step(0, 0, 0, 0);
        settle();
        chk("pause_release_tick", 64'(tick), 64'h1);

        // CN with pause at prescaler P-1
        repeat (7) step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        settle();
        chk("cn_pause_no_tick", 64'(tick), 64'h0);
        chk("cn_pause_state", 64'(state), 64'h1);
        step(0, 0, 0, 1);
        settle();
        chk("cn_pause_lanes", 64'(lanes), 64'h6030180C0603);
        repeat (10) step(0, 0, 0, 1);

        // level 3: one shift per cycle
        step(0, 1, 3, 0);
        step(0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        settle();
        chk("fast_tick", 64'(tick), 64'h1);
`ifndef CV_LFSR_EN
        chk("fast_wrap_lane0", 64'(lanes[7:0]), 64'h03);
`endif

        // reset mid-run, restart
        step(1, 0, 0, 0);
        settle();
        chk("rst_lanes", 64'(lanes), 64'h0);
        chk("rst_state", 64'(state), 64'h0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        settle();
`ifdef CV_LFSR_EN
        chk("restart_lane0", 64'(lanes[7:0]), 64'h07);
`else
        chk("restart_lane0", 64'(lanes[7:0]), 64'h06);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 300) == 0, ($urandom % 25) == 0, 2'($urandom), ($urandom % 6) == 0);
        end
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        settle();
        chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
